// File: rtl/mac_operand_feeder_if.sv
// Upstream valid/ready operand channel feeding mac_operand_feeder.
// master = operand source, slave = feeder.
interface mac_operand_feeder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_c;
    logic [WIDTH-1:0] in_d;
    logic             in_last;

    modport master (
        output in_valid, in_a, in_b, in_c, in_d, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, in_d, in_last,
        output in_ready
    );
endinterface

// File: rtl/mac_operand_feeder.sv
// Buffers operand quadruples in a small FIFO and presents one per clock to a
// dual-product MAC; zero operands when idle, done/vec_len mark vector completion.
module mac_operand_feeder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    mac_operand_feeder_if.slave      up,
    input  logic                     stall,
    output logic [WIDTH-1:0]         a,
    output logic [WIDTH-1:0]         b,
    output logic [WIDTH-1:0]         c,
    output logic [WIDTH-1:0]         d,
    output logic                     done,
    output logic [CNT_W-1:0]         vec_len,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] d;
        logic             last;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  len_q;
    logic              last_q;

    logic              push;
    logic              pop;
    entry_t            head;
    logic [CNT_W-1:0]  count_inc;

    // in_ready depends only on the registered level, never on stall/in_valid.
    assign up.in_ready = (fifo_level != LW'(DEPTH));
    assign push        = up.in_valid && up.in_ready;
    assign pop         = !stall && (fifo_level != '0);
    assign head        = mem[rd_ptr];
    assign count_inc   = (count == '1) ? count : count + 1'b1;

    // NOTE: the storage array has no reset; pointers and level define which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= '{a: up.in_a, b: up.in_b, c: up.in_c, d: up.in_d, last: up.in_last};
        end
    end

    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            a          <= '0;
            b          <= '0;
            c          <= '0;
            d          <= '0;
            count      <= '0;
            len_q      <= '0;
            last_q     <= 1'b0;
            done       <= 1'b0;
            vec_len    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase

            // Zero operands on every non-pop edge so the MAC holds its value.
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                a      <= head.a;
                b      <= head.b;
                c      <= head.c;
                d      <= head.d;
                if (head.last) begin
                    count <= '0;
                    len_q <= count_inc;
                end else begin
                    count <= count_inc;
                end
            end else begin
                a <= '0;
                b <= '0;
                c <= '0;
                d <= '0;
            end

            // One-stage delay aligns done with the MAC having absorbed the last product.
            last_q <= pop && head.last;
            done   <= last_q;
            if (last_q) begin
                vec_len <= len_q;
            end
        end
    end
endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder with a behavioural dual-product MAC
// downstream (acc <= acc + a*b + c*d) to check end-to-end accumulator values.
module tb_mac_operand_feeder;
    logic        clock;
    logic        reset;
    logic        stall;
    logic [7:0]  a, b, c, d;
    logic        done;
    logic [15:0] vec_len;
    logic [2:0]  fifo_level;

    logic        stall_s;
    logic [7:0]  a_s, b_s, c_s, d_s;
    logic        done_s;
    logic [2:0]  vec_len_s;
    logic [2:0]  fifo_level_s;

    logic [31:0] acc;
    int          errors;
    int          checks;

    mac_operand_feeder_if #(.WIDTH(8)) bus   ();
    mac_operand_feeder_if #(.WIDTH(8)) bus_s ();

    mac_operand_feeder #(.WIDTH(8), .DEPTH(4), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .up(bus.slave), .stall(stall),
        .a(a), .b(b), .c(c), .d(d), .done(done), .vec_len(vec_len),
        .fifo_level(fifo_level)
    );

    mac_operand_feeder #(.WIDTH(8), .DEPTH(4), .CNT_W(3)) dut_sat (
        .clock(clock), .reset(reset), .up(bus_s.slave), .stall(stall_s),
        .a(a_s), .b(b_s), .c(c_s), .d(d_s), .done(done_s), .vec_len(vec_len_s),
        .fifo_level(fifo_level_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model of the downstream MAC sharing clock and reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) acc <= '0;
        else        acc <= acc + 32'(a) * 32'(b) + 32'(c) * 32'(d);
    end

    function automatic logic [31:0] quad(input logic [7:0] qa, qb, qc, qd);
        return {qa, qb, qc, qd};
    endfunction

    task automatic set_in(input logic v, input logic [7:0] ia, ib, ic, id, input logic il);
        bus.in_valid = v;
        bus.in_a = ia; bus.in_b = ib; bus.in_c = ic; bus.in_d = id;
        bus.in_last = il;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0;
        set_in(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        stall = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if ({a, b, c, d} !== 32'd0) begin errors++; $display("FAIL reset_ops got %h want 0", {a, b, c, d}); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (vec_len !== 16'd0) begin errors++; $display("FAIL reset_vec_len got %0d want 0", vec_len); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.in_ready); end
        checks++; if (acc !== 32'd0) begin errors++; $display("FAIL reset_acc got %0d want 0", acc); end
    endtask

    task automatic test_single_vector();
        apply_reset();
        @(negedge clock); set_in(1'b1, 8'd10, 8'd20, 8'd12, 8'd5, 1'b0);
        tick();
        checks++; if ({a, b, c, d} !== 32'd0) begin errors++; $display("FAIL single_no_bypass got %h want 0", {a, b, c, d}); end
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_level got %0d want 1", fifo_level); end
        @(negedge clock); set_in(1'b1, 8'd20, 8'd30, 8'd112, 8'd50, 1'b1);
        tick();
        checks++; if ({a, b, c, d} !== quad(10, 20, 12, 5)) begin errors++; $display("FAIL single_q1 got %h want %h", {a, b, c, d}, quad(10, 20, 12, 5)); end
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_level_pushpop got %0d want 1", fifo_level); end
        @(negedge clock); set_in(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        tick();
        checks++; if ({a, b, c, d} !== quad(20, 30, 112, 50)) begin errors++; $display("FAIL single_q2 got %h want %h", {a, b, c, d}, quad(20, 30, 112, 50)); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_early got %b want 0", done); end
        tick();
        checks++; if ({a, b, c, d} !== 32'd0) begin errors++; $display("FAIL single_idle got %h want 0", {a, b, c, d}); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done got %b want 1", done); end
        checks++; if (vec_len !== 16'd2) begin errors++; $display("FAIL single_vec_len got %0d want 2", vec_len); end
        checks++; if (acc !== 32'd6460) begin errors++; $display("FAIL single_acc got %0d want 6460", acc); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got %b want 0", done); end
        checks++; if (vec_len !== 16'd2) begin errors++; $display("FAIL single_vec_len_hold got %0d want 2", vec_len); end
        checks++; if (acc !== 32'd6460) begin errors++; $display("FAIL single_acc_hold got %0d want 6460", acc); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        @(negedge clock); set_in(1'b1, 8'd55, 8'd55, 8'd55, 8'd55, 1'b1);
        tick();
        @(negedge clock); set_in(1'b1, 8'd20, 8'd21, 8'd90, 8'd54, 1'b1);
        tick();
        @(negedge clock); set_in(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        tick();
        checks++; if (done !== 1'b1 || vec_len !== 16'd1) begin errors++; $display("FAIL b2b_done1 got done=%b len=%0d want 1/1", done, vec_len); end
        checks++; if (acc !== 32'd6050) begin errors++; $display("FAIL b2b_acc1 got %0d want 6050", acc); end
        tick();
        checks++; if (done !== 1'b1 || vec_len !== 16'd1) begin errors++; $display("FAIL b2b_done2 got done=%b len=%0d want 1/1", done, vec_len); end
        checks++; if (acc !== 32'd11330) begin errors++; $display("FAIL b2b_acc2 got %0d want 11330", acc); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_end got %b want 0", done); end
    endtask

    task automatic test_full();
        logic [32:0] qv [5];
        int          idx;
        logic        rdy;
        logic        pushed;
        qv[0] = {8'd1, 8'd2, 8'd3, 8'd4, 1'b0};
        qv[1] = {8'd5, 8'd6, 8'd7, 8'd8, 1'b0};
        qv[2] = {8'd9, 8'd10, 8'd11, 8'd12, 1'b0};
        qv[3] = {8'd13, 8'd14, 8'd15, 8'd16, 1'b0};
        qv[4] = {8'd17, 8'd18, 8'd19, 8'd20, 1'b1};
        apply_reset();
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            stall = 1'b1;
            set_in(1'b1, qv[idx][32:25], qv[idx][24:17], qv[idx][16:9], qv[idx][8:1], qv[idx][0]);
            rdy = bus.in_ready;
            tick();
            if (rdy) idx++;
            checks++; if ({a, b, c, d} !== 32'd0) begin errors++; $display("FAIL full_stall_ops got %h want 0", {a, b, c, d}); end
        end
        checks++; if (idx !== 4) begin errors++; $display("FAIL full_accepted got %0d want 4", idx); end
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_level got %0d want 4", fifo_level); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", bus.in_ready); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            stall = 1'b0;
            if (idx < 5) set_in(1'b1, qv[idx][32:25], qv[idx][24:17], qv[idx][16:9], qv[idx][8:1], qv[idx][0]);
            else         set_in(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
            pushed = bus.in_ready && (idx < 5);
            tick();
            if (pushed) idx++;
            checks++; if ({a, b, c, d} !== qv[k][32:1]) begin errors++; $display("FAIL full_order%0d got %h want %h", k, {a, b, c, d}, qv[k][32:1]); end
        end
        tick();
        checks++; if (done !== 1'b1 || vec_len !== 16'd5) begin errors++; $display("FAIL full_done got done=%b len=%0d want 1/5", done, vec_len); end
    endtask

    task automatic test_stall_mid();
        apply_reset();
        @(negedge clock); set_in(1'b1, 8'd3, 8'd4, 8'd5, 8'd6, 1'b0);
        tick();
        @(negedge clock); set_in(1'b1, 8'd7, 8'd8, 8'd9, 8'd10, 1'b1);
        tick();
        checks++; if ({a, b, c, d} !== quad(3, 4, 5, 6)) begin errors++; $display("FAIL stall_r1 got %h want %h", {a, b, c, d}, quad(3, 4, 5, 6)); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); stall = 1'b1; set_in(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
            tick();
            checks++; if ({a, b, c, d} !== 32'd0 || done !== 1'b0) begin errors++; $display("FAIL stall_hold%0d got ops=%h done=%b want 0/0", i, {a, b, c, d}, done); end
            checks++; if (i > 0 && acc !== 32'd42) begin errors++; $display("FAIL stall_acc%0d got %0d want 42", i, acc); end
        end
        @(negedge clock); stall = 1'b0;
        tick();
        checks++; if ({a, b, c, d} !== quad(7, 8, 9, 10) || done !== 1'b0) begin errors++; $display("FAIL stall_r2 got ops=%h done=%b", {a, b, c, d}, done); end
        tick();
        checks++; if (done !== 1'b1 || vec_len !== 16'd2) begin errors++; $display("FAIL stall_done got done=%b len=%0d want 1/2", done, vec_len); end
        checks++; if (acc !== 32'd188) begin errors++; $display("FAIL stall_acc got %0d want 188", acc); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            stall = 1'b1;
            if (i == 0) set_in(1'b1, 8'd1, 8'd1, 8'd1, 8'd1, 1'b1);
            else        set_in(1'b1, 8'(i + 1), 8'(i + 2), 8'(i + 3), 8'(i + 4), 1'b0);
            tick();
        end
        @(negedge clock); stall = 1'b0; set_in(1'b1, 8'd40, 8'd41, 8'd42, 8'd43, 1'b0);
        tick();
        tick();
        checks++; if ({a, b, c, d} !== quad(2, 3, 4, 5)) begin errors++; $display("FAIL areset_pre_ops got %h want %h", {a, b, c, d}, quad(2, 3, 4, 5)); end
        checks++; if (done !== 1'b1 || fifo_level !== 3'd3) begin errors++; $display("FAIL areset_pre got done=%b level=%0d want 1/3", done, fifo_level); end
        #1;
        reset = 1'b0;
        set_in(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        #1;
        checks++; if ({a, b, c, d} !== 32'd0) begin errors++; $display("FAIL areset_ops got %h want 0", {a, b, c, d}); end
        checks++; if (done !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL areset_state got done=%b level=%0d want 0/0", done, fifo_level); end
        checks++; if (vec_len !== 16'd0 || acc !== 32'd0) begin errors++; $display("FAIL areset_len_acc got len=%0d acc=%0d want 0/0", vec_len, acc); end
        @(negedge clock); reset = 1'b1;
        @(negedge clock); set_in(1'b1, 8'd6, 8'd7, 8'd8, 8'd9, 1'b1);
        tick();
        @(negedge clock); set_in(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        tick();
        checks++; if ({a, b, c, d} !== quad(6, 7, 8, 9)) begin errors++; $display("FAIL areset_new_ops got %h want %h", {a, b, c, d}, quad(6, 7, 8, 9)); end
        tick();
        checks++; if (done !== 1'b1 || vec_len !== 16'd1) begin errors++; $display("FAIL areset_new_done got done=%b len=%0d want 1/1", done, vec_len); end
        checks++; if (acc !== 32'd114) begin errors++; $display("FAIL areset_new_acc got %0d want 114", acc); end
    endtask

    task automatic test_saturation();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            bus_s.in_valid = 1'b1;
            bus_s.in_a = 8'(i); bus_s.in_b = 8'd1; bus_s.in_c = 8'd2; bus_s.in_d = 8'd3;
            bus_s.in_last = (i == 8);
            tick();
        end
        @(negedge clock); bus_s.in_valid = 1'b0; bus_s.in_last = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            if (done_s) got = 1'b1;
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL sat_done_timeout got %b want 1", got); end
        checks++; if (vec_len_s !== 3'd7) begin errors++; $display("FAIL sat_vec_len got %0d want 7", vec_len_s); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b0;
        stall = 1'b0;
        stall_s = 1'b0;
        set_in(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        bus_s.in_valid = 1'b0;
        bus_s.in_a = '0; bus_s.in_b = '0; bus_s.in_c = '0; bus_s.in_d = '0;
        bus_s.in_last = 1'b0;
        #12;
        test_reset();
        test_single_vector();
        test_back_to_back();
        test_full();
        test_stall_mid();
        test_async_reset();
        apply_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
